// File: rtl/reg_file_mp.sv
// Multi-read-port register file with posedge write, optional zero register and a
// hardware clear sweep (busy). Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_is_zero;

  assign wr_is_zero = (ZERO_REG != 0) && (wr_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // The sweep shares the single array write port; user writes only reach it in IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    busy      = 1'b0;
    unique case (state)
      SWEEP: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
        if (ptr == AW'(DEPTH - 1)) state_nxt = IDLE;
        else                       ptr_nxt   = ptr + AW'(1);
      end
      IDLE: begin
        if (clear) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end else begin
          mem_we = wr_en && !wr_is_zero;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [AW-1:0]     ra;
  logic [DATA_W-1:0] val;

  always_comb begin
    rd_data = '0;
    ra      = '0;
    val     = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra  = rd_addr[k*AW +: AW];
      val = mem[ra];
      if ((ZERO_REG != 0) && (ra == '0)) val = '0;
`ifdef REGFILE_BYPASS_EN
      if ((state == IDLE) && wr_en && (ra == wr_addr) && !wr_is_zero) val = wr_data;
`endif
      if (state == SWEEP) val = '0;
      rd_data[k*DATA_W +: DATA_W] = val;
    end
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the MIPS pipeline's decode stage, replacing the fixed 32x32 two-port file. It adds:
- a configurable number of read ports;
- posedge write with optional same-cycle write-to-read forwarding;
- an optional hardwired zero register;
- a hardware clear sequencer that zeroes every entry after reset or on request, flagged by `busy`.

## Interface
- `DATA_W`, 32, register width in bits
- `DEPTH`, 32, number of registers; power of two, ≥ 2; `AW = $clog2(DEPTH)`
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1 = register 0 always reads 0 and ignores writes
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  single-cycle request to zero all registers; sampled in IDLE only
- `rd_addr`  in  NUM_RD*AW  flattened read addresses; port k = bits [k*AW +: AW]
- `rd_data`  out  NUM_RD*DATA_W  flattened read data; port k = bits [k*DATA_W +: DATA_W]
- `wr_en`  in  1  write enable
- `wr_addr`  in  AW  write address
- `wr_data`  in  DATA_W  write data
- `busy`  out  1  high while the clear sweep runs

## Operation
- FSM states: SWEEP, IDLE.
- Reset (`rst_n` = 0):
  - state = SWEEP, `ptr` = 0, `busy` = 1.
  - The register array is not reset directly.
- SWEEP:
  - Each posedge writes 0 to `reg[ptr]` and increments `ptr`.
  - When `ptr == DEPTH-1` is written, go to IDLE and drop `busy`.
  - `wr_en` and `clear` are ignored.
  - All `rd_data` ports read 0.
- IDLE:
  - `wr_en` = 1 writes `wr_data` to `reg[wr_addr]` at posedge.
  - If `ZERO_REG` = 1 and `wr_addr` = 0, the write is dropped.
  - `clear` = 1 enters SWEEP at the next posedge with `ptr` = 0 and `busy` = 1. A `wr_en` in that same cycle is discarded.
- Reads are combinational: `rd_data[k] = reg[rd_addr[k]]`. If `ZERO_REG` = 1 and `rd_addr[k]` = 0, the result is 0.
- Multiple read ports may address the same register; each returns the same value.
- `rst_n` asserted mid-sweep restarts the sweep at `ptr` = 0.
- `ptr` is AW bits wide and never wraps past `DEPTH-1`.

## Timing
- Reset values: `busy` = 1, all `rd_data` = 0.
- The clear sweep takes exactly DEPTH cycles. `busy` falls after the DEPTH-th posedge following reset deassertion, or following the cycle `clear` was sampled.
- First accepted write: the first posedge with `busy` = 0.
- Write latency:
  - The written value is visible on reads after the write posedge.
  - With bypass, it is also visible combinationally in the write cycle (see Configuration).
- A read and a write to the same register in the same cycle, without bypass, returns the old value.
- Read path: combinational only, with no added latency.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Adds a forwarding mux per read port.
  - When IDLE and `wr_en` = 1 and `rd_addr[k] == wr_addr` (and not the zero register when `ZERO_REG` = 1), `rd_data[k] = wr_data` in the same cycle.
  - This removes the decode/writeback hazard.
- `REGFILE_BYPASS_EN` undefined:
  - No forwarding.
  - A same-cycle read returns the pre-write contents.

## Test plan
- Reset sweep: hold `rst_n` = 0 for 3 cycles, release. `busy` stays 1 for exactly 32 posedges, then 0. All 32 registers then read 0x00000000 on both ports.
- Write/read: after sweep, write 0x00000005 to r15 and 0x00000003 to r20. Next cycle, `rd_addr` = {20, 15} gives `rd_data` = {3, 5}.
- Zero register: write 0xDEADBEEF to r0. Reading r0 returns 0. With `ZERO_REG` = 0, the same write reads back 0xDEADBEEF.
- Same-cycle hazard: write 0x12345678 to r7 while reading r7 on port 0. With `REGFILE_BYPASS_EN`, port 0 shows 0x12345678 in that cycle. Without it, port 0 shows the prior value 0x00000000, and 0x12345678 appears next cycle.
- Clear mid-run: fill r1..r31 with their own index; pulse `clear` together with `wr_en` to r3 = 0xFF.
  - `busy` rises next cycle, and the r3 write is dropped.
  - During the sweep, writes are ignored and reads return 0.
  - After 32 cycles, all registers read 0.
- Reset mid-sweep: assert `rst_n` low at `ptr` = 10 during a sweep, release. The sweep restarts and `busy` lasts a full 32 cycles from the release. Verify with `DEPTH` = 16 and `NUM_RD` = 3 that `busy` lasts 16 cycles and all three ports read 0 afterward.
